// File: rtl/serial_word_receiver.sv
// serial_word_receiver: serial-in / parallel-out receiver with a one-word
// valid/ready output buffer. Collects N qualified bits MSB-first (Dir = 0)
// or LSB-first (Dir = 1) and hands the word to the consumer.
// Optional feature: define SERIAL_WORD_RECEIVER_PARITY_EN to expect an
// even-parity bit after the data bits and expose a ParityErr output.
module serial_word_receiver #(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic         Dir,
  input  logic         BitValid,
  input  logic         SerialIn,
  input  logic         DataReady,
  output logic [N-1:0] Data,
  output logic         DataValid,
  output logic         Busy,
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  output logic         ParityErr,
`endif
  output logic         Overrun
);

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  localparam int FRAME_LEN = N + 1;
`else
  localparam int FRAME_LEN = N;
`endif
  localparam int CW = $clog2(FRAME_LEN);

  typedef enum logic {
    IDLE,
    RECV
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   sr_q, sr_d;
  logic           order_q, order_d;
  logic [N-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           overrun_q, overrun_d;
  logic           perr_q, perr_d;

  // Word offered to the output buffer on the completing bit, plus its parity check.
  logic [N-1:0]   word;
  logic           word_perr;
  logic           data_bit;
  logic           last_bit;
  logic           word_done;

  assign last_bit = (cnt_q == CW'(FRAME_LEN - 1));

  // Assemble the completed word; with parity the last bit is the parity bit only.
  always_comb begin
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    data_bit  = (cnt_q < CW'(N));
    word      = sr_q;
    word_perr = ^{sr_q, SerialIn};
`else
    data_bit  = 1'b1;
    word      = order_q ? {SerialIn, sr_q[N-1:1]} : {sr_q[N-2:0], SerialIn};
    word_perr = 1'b0;
`endif
  end

  // Next-state logic for the frame FSM and the output buffer.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves a latch behind.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    order_d   = order_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    perr_d    = perr_q;
    word_done = 1'b0;

    // A consumer transfer empties the buffer unless a new word lands below.
    if (valid_q && DataReady) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RECV;
          cnt_d   = '0;
          sr_d    = '0;
          order_d = Dir;
        end
      end
      RECV: begin
        if (Start) begin
          // Abort and restart; a bit offered in this cycle is dropped.
          cnt_d   = '0;
          sr_d    = '0;
          order_d = Dir;
        end else if (BitValid) begin
          if (data_bit) begin
            sr_d = order_q ? {SerialIn, sr_q[N-1:1]} : {sr_q[N-2:0], SerialIn};
          end
          if (last_bit) begin
            word_done = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (!valid_q || DataReady) begin
        data_d  = word;
        valid_d = 1'b1;
        perr_d  = word_perr;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!Resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      order_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      order_q   <= order_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
    end
  end

  assign Data      = data_q;
  assign DataValid = valid_q;
  assign Busy      = (state_q == RECV);
  assign Overrun   = overrun_q;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  assign ParityErr = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: directed frames followed by random traffic,
// checked against a bit-queue reference model and an output-word scoreboard.
module tb_serial_word_receiver;

  localparam int N = 8;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  localparam int FRAME_LEN = N + 1;
`else
  localparam int FRAME_LEN = N;
`endif

  logic         Clock = 1'b0;
  logic         Resetn, Start, Dir, BitValid, SerialIn, DataReady;
  logic [N-1:0] Data;
  logic         DataValid, Busy, Overrun;
  logic         ParityErr;

  serial_word_receiver #(.N(N)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .Dir       (Dir),
    .BitValid  (BitValid),
    .SerialIn  (SerialIn),
    .DataReady (DataReady),
    .Data      (Data),
    .DataValid (DataValid),
    .Busy      (Busy),
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    .ParityErr (ParityErr),
`endif
    .Overrun   (Overrun)
  );

`ifndef SERIAL_WORD_RECEIVER_PARITY_EN
  assign ParityErr = 1'b0;
`endif

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits of the current frame kept in a queue.
  bit           m_busy, m_order, m_valid, m_overrun, m_perr;
  bit           m_bits[$];
  logic [N-1:0] m_data;
  logic [N:0]   exp_q[$];   // {parity_err, word} in load order

  function automatic logic [N-1:0] build_word(input bit order);
    int w = 0;
    for (int i = 0; i < N; i++) begin
      if (order == 1'b0) w = w * 2 + int'(m_bits[i]);
      else               w = w + (int'(m_bits[i]) << i);
    end
    return w[N-1:0];
  endfunction

  // Effect of the coming rising edge on the model.
  task automatic model_step(input bit rn, input bit st, input bit d, input bit bv,
                            input bit si, input bit rdy);
    bit done = 0;
    bit old_valid = m_valid;
    logic [N-1:0] w;
    bit pe = 0;
    if (!rn) begin
      m_busy = 0; m_order = 0; m_valid = 0; m_overrun = 0; m_perr = 0;
      m_data = '0; m_bits.delete();
      return;
    end
    if (st) begin
      m_busy = 1; m_order = d; m_bits.delete();
    end else if (m_busy && bv) begin
      m_bits.push_back(si);
      if (m_bits.size() == FRAME_LEN) begin
        done = 1;
        m_busy = 0;
      end
    end
    if (old_valid && rdy) m_valid = 0;
    if (done) begin
      w = build_word(m_order);
      foreach (m_bits[i]) pe = pe ^ m_bits[i];
      if (FRAME_LEN == N) pe = 0;
      if (!old_valid || rdy) begin
        m_data = w; m_valid = 1; m_perr = pe;
        exp_q.push_back({pe, w});
      end else begin
        m_overrun = 1;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit rn, input bit st, input bit d, input bit bv,
                       input bit si, input bit rdy);
    Resetn = rn; Start = st; Dir = d; BitValid = bv; SerialIn = si; DataReady = rdy;
    model_step(rn, st, d, bv, si, rdy);
    @(posedge Clock);
    #1;
    check("busy",    32'(Busy),      32'(m_busy));
    check("valid",   32'(DataValid), 32'(m_valid));
    check("overrun", 32'(Overrun),   32'(m_overrun));
    check("data",    32'(Data),      32'(m_data));
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    check("parity_err", 32'(ParityErr), 32'(m_perr));
`endif
  endtask

  // Full frame with optional idle gaps; DataReady only on the completing bit.
  task automatic send_frame(input bit d, input logic [N-1:0] w, input bit bad_par,
                            input bit gaps, input bit rdy_end);
    bit b;
    cycle(1, 1, d, 0, 0, 0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i < N) b = d ? w[i] : w[N-1-i];
      else       b = (^w) ^ bad_par;
      if (gaps) cycle(1, 0, 0, 0, 1'($urandom), 0);
      cycle(1, 0, 0, 1, b, (i == FRAME_LEN - 1) ? rdy_end : 1'b0);
    end
  endtask

  // Monitor: pops one expected word each time the DUT presents a new one.
  initial begin
    bit need_pop = 1;
    logic [N:0] e;
    forever begin
      @(negedge Clock);
      if (DataValid === 1'b1) begin
        if (need_pop) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'(Data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("sb_data", 32'(Data), 32'(e[N-1:0]));
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            check("sb_parity_err", 32'(ParityErr), 32'(e[N]));
`endif
          end
          need_pop = 0;
        end
        if (DataReady) need_pop = 1;
      end else begin
        need_pop = 1;
      end
    end
  end

  initial begin
    // Reset, then idle with BitValid toggling and no Start.
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, i[0], 1, 1);
    check("idle_data", 32'(Data), 32'h0);

    // MSB-first 0xA5.
    send_frame(0, 8'hA5, 0, 0, 0);
    check("msb_a5", 32'(Data), 32'hA5);
    check("msb_a5_valid", 32'(DataValid), 32'h1);
    cycle(1, 0, 0, 0, 0, 1);

    // LSB-first 0x78 with gaps, then consume.
    send_frame(1, 8'h78, 0, 1, 0);
    check("lsb_78", 32'(Data), 32'h78);
    cycle(1, 0, 0, 0, 0, 1);
    check("consumed_valid", 32'(DataValid), 32'h0);
    check("consumed_hold", 32'(Data), 32'h78);

    // Abort after 5 bits, restart with 0x3C.
    cycle(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 1, 0);
    send_frame(0, 8'h3C, 0, 0, 0);
    check("abort_3c", 32'(Data), 32'h3C);
    cycle(1, 0, 0, 0, 0, 1);

    // Overrun, then a completion coinciding with a transfer.
    send_frame(0, 8'h11, 0, 0, 0);
    send_frame(0, 8'h22, 0, 0, 0);
    check("overrun_keep", 32'(Data), 32'h11);
    check("overrun_flag", 32'(Overrun), 32'h1);
    send_frame(1, 8'h22, 0, 0, 1);
    check("swap_22", 32'(Data), 32'h22);

    // Parity good/bad, then reset mid-frame.
    send_frame(0, 8'hA5, 0, 0, 1);
    send_frame(0, 8'hA5, 1, 0, 1);
    check("par_data", 32'(Data), 32'hA5);
    cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    check("reset_busy", 32'(Busy), 32'h0);
    send_frame(0, 8'hC3, 0, 1, 0);
    check("post_reset", 32'(Data), 32'hC3);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 599) != 0),
            ($urandom_range(0, 24) == 0),
            1'($urandom),
            ($urandom_range(0, 2) != 0),
            1'($urandom),
            ($urandom_range(0, 3) == 0));
    end

    // Drain and confirm every loaded word was presented.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 1);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
